// File: rtl/awgn_channel.sv
// ---------------------------------------------------------------------------
// awgn_channel
//   Adds an attenuated Gaussian noise sample to each clean input sample and
//   saturates the result to DATA_W bits. It is a two-stage valid/ready
//   pipeline:
//     S1  captures the (DATA_W+1)-bit sum on input transfer
//     S2  clips the sum and holds it as the output register
//   A saturating counter records how many output samples were clipped.
//
// Ports
//   clk          in   sole clock, rising edge
//   nreset       in   asynchronous active-low reset
//   noise_in     in   DATA_W signed noise sample (fresh every clk)
//   noise_en     in   1 = add noise, 0 = bypass
//   noise_shift  in   4-bit arithmetic right shift applied to noise_in
//   in_data      in   DATA_W signed clean sample
//   in_valid     in   in_data valid
//   in_ready     out  block accepts in_data this cycle
//   out_data     out  DATA_W signed noisy, saturated sample
//   out_valid    out  out_data valid
//   out_ready    in   downstream accepts out_data
//   sat_clear    in   synchronous clear of sat_count (wins over increment)
//   sat_count    out  CNT_W count of clipped output samples, saturating
// ---------------------------------------------------------------------------
module awgn_channel #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic signed [DATA_W-1:0] noise_in,
  input  logic                     noise_en,
  input  logic        [3:0]        noise_shift,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     sat_clear,
  output logic        [CNT_W-1:0]  sat_count
);

  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  // Pipeline state
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W:0]   s1_sum_q,   s1_sum_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [CNT_W-1:0]  sat_count_q, sat_count_d;

  // Handshake decode
  logic s2_load;
  logic in_xfer;
  logic out_xfer;

  // Datapath intermediates
  logic signed [DATA_W-1:0] noise_term;
  logic        [DATA_W:0]   sum_now;
  logic                     clip_hi;
  logic                     clip_lo;
  logic        [DATA_W-1:0] clipped;

  // S2 can take S1's sample when it is empty or is being emptied this cycle.
  assign s2_load  = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s2_load;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid_q && out_ready;

  // Noise is only consumed on an input transfer; other samples fall away.
  always_comb begin
    noise_term = '0;
    if (noise_en) begin
      noise_term = noise_in >>> noise_shift;
    end
    sum_now = {in_data[DATA_W-1], in_data} + {noise_term[DATA_W-1], noise_term};
  end

  // The sum of two DATA_W values always fits DATA_W+1 bits, so overflow of
  // the DATA_W result shows up as the two top bits disagreeing.
  always_comb begin
    clip_hi = !s1_sum_q[DATA_W] &&  s1_sum_q[DATA_W-1];
    clip_lo =  s1_sum_q[DATA_W] && !s1_sum_q[DATA_W-1];
    clipped = s1_sum_q[DATA_W-1:0];
    if (clip_hi) begin
      clipped = SAT_MAX;
    end else if (clip_lo) begin
      clipped = SAT_MIN;
    end
  end

  // S1 next state
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_sum_d   = sum_now;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  // S2 next state: a load during an output transfer replaces the data with
  // no bubble; data is untouched while stalled.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (s2_load) begin
      out_valid_d = 1'b1;
      out_data_d  = clipped;
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  // Clip counter: clear has priority, and the count sticks at all-ones.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (s2_load && (clip_hi || clip_lo) && !(&sat_count_q)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_awgn_channel.sv
// ---------------------------------------------------------------------------
// tb_awgn_channel
//   Directed bench for awgn_channel: reset state, bypass latency, a table of
//   add/shift/clip vectors, backpressure ordering, counter saturation and
//   clear priority, and asynchronous reset with both stages full.
// ---------------------------------------------------------------------------
module tb_awgn_channel;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 16;

  logic                     clk;
  logic                     nreset;
  logic signed [DATA_W-1:0] noise_in;
  logic                     noise_en;
  logic        [3:0]        noise_shift;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     sat_clear;
  logic        [CNT_W-1:0]  sat_count;

  int n_checks;
  int n_fail;

  awgn_channel #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .nreset     (nreset),
    .noise_in   (noise_in),
    .noise_en   (noise_en),
    .noise_shift(noise_shift),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sat_clear  (sat_clear),
    .sat_count  (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic signed [DATA_W-1:0] din;
    logic signed [DATA_W-1:0] nin;
    logic                     en;
    logic        [3:0]        sh;
    logic signed [DATA_W-1:0] exp_out;
    int                       exp_sat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t tbl[NVEC];

  // out_ready pattern for the backpressure run, consumed LSB first
  logic [31:0] rdy_pat;

  initial begin
    int idx;
    int oidx;
    int occ;
    int k;
    int nout;
    logic in_x;
    logic out_x;
    logic stall_pending;
    logic signed [DATA_W-1:0] stall_data;

    n_checks = 0;
    n_fail   = 0;
    rdy_pat  = 32'hE38E_3C71;

    //            din     nin    en  sh  exp     sat
    tbl[0]  = '{  100,  -1600, 1'b1, 4,      0, 0};
    tbl[1]  = '{  100,  -1600, 1'b1, 0,  -1500, 0};
    tbl[2]  = '{32000,   1000, 1'b1, 0,  32767, 1};
    tbl[3]  = '{-32768,    -1, 1'b1, 0, -32768, 2};
    tbl[4]  = '{32767,  32767, 1'b1, 0,  32767, 3};
    tbl[5]  = '{-32768,-32768, 1'b1, 0, -32768, 4};
    tbl[6]  = '{32767,      0, 1'b1, 0,  32767, 4};
    tbl[7]  = '{-32768,     0, 1'b1, 0, -32768, 4};
    tbl[8]  = '{32000,    767, 1'b1, 0,  32767, 4};
    tbl[9]  = '{32000,    768, 1'b1, 0,  32767, 5};
    tbl[10] = '{    5,     -7, 1'b1, 15,     4, 5};
    tbl[11] = '{    5,  30000, 1'b0, 0,      5, 5};
    tbl[12] = '{ -100,      7, 1'b1, 1,    -97, 5};
    tbl[13] = '{    0, -32768, 1'b1, 15,    -1, 5};

    nreset      = 1'b0;
    noise_in    = '0;
    noise_en    = 1'b0;
    noise_shift = '0;
    in_data     = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    sat_clear   = 1'b0;

    // ---------------- reset state ----------------
    #2;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_sat_count", sat_count, 0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // ---------------- bypass latency ----------------
    noise_en = 1'b0;
    noise_in = 16'sd12345;
    in_valid = 1'b1;
    in_data  = 16'sd1000;
    @(negedge clk);
    check("byp_c0_ready", in_ready, 1);
    check("byp_c0_valid", out_valid, 0);
    tick();
    in_data = 16'sd200;
    @(negedge clk);
    check("byp_c1_valid", out_valid, 0);
    tick();
    in_data = -16'sd5;
    @(negedge clk);
    check("byp_c2_valid", out_valid, 1);
    check("byp_c2_data",  out_data,  1000);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("byp_c3_valid", out_valid, 1);
    check("byp_c3_data",  out_data,  200);
    tick();
    @(negedge clk);
    check("byp_c4_valid", out_valid, 1);
    check("byp_c4_data",  out_data,  -5);
    tick();
    @(negedge clk);
    check("byp_c5_valid", out_valid, 0);
    $display("bypass: 1000 200 -5 checked");
    tick();

    // ---------------- table vectors, back-to-back ----------------
    idx  = 0;
    oidx = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < NVEC + 20 && oidx < NVEC; cyc++) begin
      if (idx < NVEC) begin
        in_valid    = 1'b1;
        in_data     = tbl[idx].din;
        noise_in    = tbl[idx].nin;
        noise_en    = tbl[idx].en;
        noise_shift = tbl[idx].sh;
      end else begin
        in_valid = 1'b0;
        noise_in = 16'sd999;
      end
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        $display("vec %0d: out_data=%0d sat_count=%0d", oidx, out_data, sat_count);
        check($sformatf("vec%0d_data", oidx), out_data, tbl[oidx].exp_out);
        check($sformatf("vec%0d_sat", oidx), sat_count, tbl[oidx].exp_sat);
        oidx++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("vec_count", oidx, NVEC);

    // ---------------- backpressure, 1..10 ----------------
    noise_en      = 1'b0;
    noise_shift   = '0;
    occ           = 0;
    k             = 1;
    nout          = 0;
    stall_pending = 1'b0;
    stall_data    = '0;
    for (int cyc = 0; cyc < 300 && nout < 10; cyc++) begin
      out_ready = rdy_pat[cyc % 32];
      in_valid  = (k <= 10);
      in_data   = DATA_W'(k);
      noise_in  = DATA_W'(cyc * 37);
      @(negedge clk);
      if (stall_pending) begin
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_data",  out_data,  stall_data);
      end
      check("bp_in_ready", in_ready, (occ == 2 && !out_ready) ? 0 : 1);
      in_x  = in_valid && in_ready;
      out_x = out_valid && out_ready;
      if (out_x) begin
        $display("bp out: %0d", out_data);
        check("bp_order", out_data, nout + 1);
        nout++;
      end
      stall_pending = out_valid && !out_ready;
      stall_data    = out_data;
      occ = occ + (in_x ? 1 : 0) - (out_x ? 1 : 0);
      if (in_x) k++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", nout, 10);
    repeat (3) tick();
    @(negedge clk);
    check("bp_drained", out_valid, 0);
    tick();

    // ---------------- counter clear and saturation ----------------
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    @(negedge clk);
    check("cnt_cleared", sat_count, 0);
    tick();
    in_valid    = 1'b1;
    in_data     = 16'sd32767;
    noise_in    = 16'sd1;
    noise_en    = 1'b1;
    noise_shift = '0;
    repeat (65540) @(posedge clk);
    #1;
    @(negedge clk);
    check("cnt_saturated", sat_count, 65535);
    tick();
    @(negedge clk);
    check("cnt_holds", sat_count, 65535);
    tick();
    // clear in the same cycle as a clipped S2 load
    sat_clear = 1'b1;
    tick();
    sat_clear = 1'b0;
    @(negedge clk);
    check("cnt_clear_wins", sat_count, 0);
    tick();
    @(negedge clk);
    check("cnt_after_clear", sat_count, 1);
    $display("counter: saturate/hold/clear checked");
    tick();

    // ---------------- reset mid-stream ----------------
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'sd32767;
    noise_in  = 16'sd5;
    noise_en  = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("mid_full_ready", in_ready,  0);
    check("mid_full_valid", out_valid, 1);
    #2;
    nreset = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sat",   sat_count, 0);
    check("mid_rst_ready", in_ready,  1);
    check("mid_rst_data",  out_data,  0);
    @(negedge clk);
    nreset    = 1'b1;
    in_valid  = 1'b1;
    in_data   = 16'sd77;
    noise_en  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_c1_valid", out_valid, 0);
    tick();
    @(negedge clk);
    check("post_rst_c2_valid", out_valid, 1);
    check("post_rst_c2_data",  out_data,  77);
    tick();
    @(negedge clk);
    check("post_rst_c3_valid", out_valid, 0);
    check("post_rst_sat",      sat_count, 0);
    $display("reset mid-stream checked");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
